// File: rtl/rvv_strip_encoder_pkg.sv
// Shared RVV types and pure encoders for the strip-mining instruction generator.
// Everything here is combinational; the top module only sequences and registers.
package rvv_strip_encoder_pkg;

   localparam logic [6:0] OpcodeVec = 7'b1010111;

   typedef enum logic [2:0] {
      EW8    = 3'd0,
      EW16   = 3'd1,
      EW32   = 3'd2,
      EW64   = 3'd3,
      EW128  = 3'd4,
      EW256  = 3'd5,
      EW512  = 3'd6,
      EW1024 = 3'd7
   } vew_e;

   typedef enum logic [2:0] {
      LMUL_1    = 3'd0,
      LMUL_2    = 3'd1,
      LMUL_4    = 3'd2,
      LMUL_8    = 3'd3,
      LMUL_RSVD = 3'd4,
      LMUL_1_8  = 3'd5,
      LMUL_1_4  = 3'd6,
      LMUL_1_2  = 3'd7
   } vlmul_e;

   typedef struct packed {
      logic   vill;
      logic   vma;
      logic   vta;
      vew_e   vsew;
      vlmul_e vlmul;
   } vtype_t;

   typedef enum logic [2:0] {
      OPIVV = 3'b000,
      OPFVV = 3'b001,
      OPMVV = 3'b010,
      OPIVI = 3'b011,
      OPIVX = 3'b100,
      OPFVF = 3'b101,
      OPMVX = 3'b110,
      OPCFG = 3'b111
   } opcodev_func3_e;

   // Fractional codes 5..7 encode 1/8, 1/4, 1/2: the right-shift amount is 8 - code.
   function automatic logic [31:0] vlmax(vew_e vsew, vlmul_e vlmul, int unsigned vlen);
      logic [31:0] base;
      base = (vlen / 32'd8) >> vsew;
      if (vlmul[2])
         return base >> (4'd8 - {1'b0, vlmul});
      else
         return base << vlmul;
   endfunction

   function automatic logic vtype_legal(vtype_t vt, int unsigned elen);
      int unsigned sew;
      sew = 32'd8 << vt.vsew;
      if (vt.vlmul == LMUL_RSVD)
         return 1'b0;
      if (sew > elen)
         return 1'b0;
      if (vt.vlmul[2] && (sew > (elen >> (4'd8 - {1'b0, vt.vlmul}))))
         return 1'b0;
      return 1'b1;
   endfunction

   function automatic logic [31:0] enc_vsetvli(vtype_t vt, logic [4:0] rs1, logic [4:0] rd);
      return {1'b0, 3'b000, vt.vma, vt.vta, vt.vsew, vt.vlmul, rs1, OPCFG, rd, OpcodeVec};
   endfunction

   function automatic logic [31:0] enc_vsetivli(vtype_t vt, logic [4:0] uimm5, logic [4:0] rd);
      return {2'b11, 2'b00, vt.vma, vt.vta, vt.vsew, vt.vlmul, uimm5, OPCFG, rd, OpcodeVec};
   endfunction

   function automatic logic [31:0] enc_varith(logic [5:0] func6, logic vm, logic [4:0] vs2,
                                              logic [4:0] vs1, opcodev_func3_e func3,
                                              logic [4:0] vd);
      return {func6, vm, vs2, vs1, func3, vd, OpcodeVec};
   endfunction

endpackage

// File: rtl/rvv_strip_encoder.sv
// Strip-mining RVV instruction generator: one job in, alternating vset/arith words out
// until the application vector length is used up.
//
// state | meaning
// IDLE  | ready for a job; rejects illegal jobs, finishes avl==0 jobs immediately
// VSET  | presenting vsetvli/vsetivli for the current strip
// ARITH | presenting the arithmetic word; on handshake retires vl elements
module rvv_strip_encoder
   import rvv_strip_encoder_pkg::*;
#(
   parameter int unsigned VLEN     = 4096,
   parameter int unsigned ELEN     = 64,
   parameter int unsigned AvlWidth = 32
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                job_valid_i,
   output logic                job_ready_o,
   input  logic [AvlWidth-1:0] job_avl_i,
   input  vtype_t              job_vtype_i,
   input  logic [5:0]          job_func6_i,
   input  opcodev_func3_e      job_func3_i,
   input  logic                job_vm_i,
   input  logic [4:0]          job_vd_i,
   input  logic [4:0]          job_vs2_i,
   input  logic [4:0]          job_vs1_i,
   input  logic [4:0]          job_rs1_i,
   input  logic [4:0]          job_rd_i,
   output logic                instr_valid_o,
   input  logic                instr_ready_i,
   output logic [31:0]         instr_o,
   output logic [AvlWidth-1:0] vl_o,
   output logic                done_o,
   output logic                err_o
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      VSET  = 2'd1,
      ARITH = 2'd2
   } state_e;

   state_e         state;
   logic [AvlWidth-1:0] remaining;
   logic           vma_q;
   logic           vta_q;
   vew_e           vsew_q;
   vlmul_e         vlmul_q;
   logic [5:0]     func6_q;
   opcodev_func3_e func3_q;
   logic           vm_q;
   logic [4:0]     vd_q;
   logic [4:0]     vs2_q;
   logic [4:0]     vs1_q;
   logic [4:0]     rs1_q;
   logic [4:0]     rd_q;

   vtype_t              vtype_q;
   logic [31:0]         vlmax_job;
   logic [31:0]         vlmax_q;
   logic                job_ok;
   logic [AvlWidth-1:0] rem_next;
   logic                unused_vill;

   // vill is a read-only status bit; a request cannot set it.
   assign unused_vill = job_vtype_i.vill;

   function automatic logic [AvlWidth-1:0] clamp_vl(logic [AvlWidth-1:0] rem, logic [31:0] vmax);
      if (64'(rem) < 64'(vmax))
         return rem;
      else
         return AvlWidth'(vmax);
   endfunction

   // Short remainders fit the 5-bit immediate, so no scalar register is needed.
   function automatic logic [31:0] vset_word(vtype_t vt, logic [AvlWidth-1:0] rem,
                                             logic [4:0] rs1, logic [4:0] rd);
      if (rem < AvlWidth'(32))
         return enc_vsetivli(vt, rem[4:0], rd);
      else
         return enc_vsetvli(vt, rs1, rd);
   endfunction

   always_comb begin
      vtype_q   = '{vill: 1'b0, vma: vma_q, vta: vta_q, vsew: vsew_q, vlmul: vlmul_q};
      vlmax_job = vlmax(job_vtype_i.vsew, job_vtype_i.vlmul, VLEN);
      vlmax_q   = vlmax(vsew_q, vlmul_q, VLEN);
      job_ok    = vtype_legal(job_vtype_i, ELEN) &&
                  ((job_func3_i == OPIVV) || (job_func3_i == OPIVX) || (job_func3_i == OPIVI));
      rem_next  = remaining - vl_o;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state         <= IDLE;
         job_ready_o   <= 1'b1;
         instr_valid_o <= 1'b0;
         instr_o       <= '0;
         vl_o          <= '0;
         done_o        <= 1'b0;
         err_o         <= 1'b0;
         remaining     <= '0;
         vma_q         <= 1'b0;
         vta_q         <= 1'b0;
         vsew_q        <= EW8;
         vlmul_q       <= LMUL_1;
         func6_q       <= '0;
         func3_q       <= OPIVV;
         vm_q          <= 1'b0;
         vd_q          <= '0;
         vs2_q         <= '0;
         vs1_q         <= '0;
         rs1_q         <= '0;
         rd_q          <= '0;
      end else begin
         done_o <= 1'b0;
         err_o  <= 1'b0;
         case (state)
            IDLE: begin
               if (job_valid_i && job_ready_o) begin
                  remaining <= job_avl_i;
                  vma_q     <= job_vtype_i.vma;
                  vta_q     <= job_vtype_i.vta;
                  vsew_q    <= job_vtype_i.vsew;
                  vlmul_q   <= job_vtype_i.vlmul;
                  func6_q   <= job_func6_i;
                  func3_q   <= job_func3_i;
                  vm_q      <= job_vm_i;
                  vd_q      <= job_vd_i;
                  vs2_q     <= job_vs2_i;
                  vs1_q     <= job_vs1_i;
                  rs1_q     <= job_rs1_i;
                  rd_q      <= job_rd_i;
                  if (!job_ok) begin
                     err_o <= 1'b1;
                  end else if (job_avl_i == '0) begin
                     done_o <= 1'b1;
                  end else begin
                     state         <= VSET;
                     job_ready_o   <= 1'b0;
                     instr_valid_o <= 1'b1;
                     vl_o          <= clamp_vl(job_avl_i, vlmax_job);
                     instr_o       <= vset_word(job_vtype_i, job_avl_i, job_rs1_i, job_rd_i);
                  end
               end
            end
            VSET: begin
               if (instr_ready_i) begin
                  state   <= ARITH;
                  instr_o <= enc_varith(func6_q, vm_q, vs2_q, vs1_q, func3_q, vd_q);
               end
            end
            ARITH: begin
               if (instr_ready_i) begin
                  remaining <= rem_next;
                  if (rem_next == '0) begin
                     state         <= IDLE;
                     instr_valid_o <= 1'b0;
                     job_ready_o   <= 1'b1;
                     done_o        <= 1'b1;
                  end else begin
                     state   <= VSET;
                     vl_o    <= clamp_vl(rem_next, vlmax_q);
                     instr_o <= vset_word(vtype_q, rem_next, rs1_q, rd_q);
                  end
               end
            end
            default: begin
               state         <= IDLE;
               instr_valid_o <= 1'b0;
               job_ready_o   <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_rvv_strip_encoder.sv
// Directed bench for the strip encoder: instruction words and vl values are hand-encoded.
module tb_rvv_strip_encoder;
   import rvv_strip_encoder_pkg::*;

   logic           clk_i = 1'b0;
   logic           rst_i;
   logic           job_valid_i;
   logic           job_ready_o;
   logic [31:0]    job_avl_i;
   vtype_t         job_vtype_i;
   logic [5:0]     job_func6_i;
   opcodev_func3_e job_func3_i;
   logic           job_vm_i;
   logic [4:0]     job_vd_i;
   logic [4:0]     job_vs2_i;
   logic [4:0]     job_vs1_i;
   logic [4:0]     job_rs1_i;
   logic [4:0]     job_rd_i;
   logic           instr_valid_o;
   logic           instr_ready_i;
   logic [31:0]    instr_o;
   logic [31:0]    vl_o;
   logic           done_o;
   logic           err_o;

   rvv_strip_encoder #(.VLEN(4096), .ELEN(64), .AvlWidth(32)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .job_valid_i(job_valid_i), .job_ready_o(job_ready_o),
      .job_avl_i(job_avl_i), .job_vtype_i(job_vtype_i),
      .job_func6_i(job_func6_i), .job_func3_i(job_func3_i), .job_vm_i(job_vm_i),
      .job_vd_i(job_vd_i), .job_vs2_i(job_vs2_i), .job_vs1_i(job_vs1_i),
      .job_rs1_i(job_rs1_i), .job_rd_i(job_rd_i),
      .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
      .instr_o(instr_o), .vl_o(vl_o), .done_o(done_o), .err_o(err_o)
   );

   always #5 clk_i = ~clk_i;

   // rs1=10, rd=5; arith word fields vd=1, vs2=2, vm=1, func6=0
   localparam logic [31:0] W_VSETVLI_E32  = 32'h010572D7;
   localparam logic [31:0] W_VSETVLI_E8   = 32'h000572D7;
   localparam logic [31:0] W_VSETIVLI_20  = 32'hC10A72D7;
   localparam logic [31:0] W_VSETIVLI_31  = 32'hC10FF2D7;
   localparam logic [31:0] W_VADD_VV      = 32'h022180D7;
   localparam logic [31:0] W_VADD_VI7     = 32'h0223B0D7;

   int errors = 0;
   int checks = 0;

   logic [31:0] words [8];
   logic [31:0] vls   [8];
   int nwords;
   bit got_done;
   bit got_err;
   int hs_cycle;
   int end_cycle;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic submit(input logic [31:0] avl, input vew_e sew, input vlmul_e lmul,
                         input opcodev_func3_e f3, input logic [4:0] vs1);
      @(negedge clk_i);
      for (int c = 0; c < 50 && !job_ready_o; c++) @(negedge clk_i);
      if (!job_ready_o) check("job_ready_wait", 32'(job_ready_o), 32'd1);
      job_avl_i   = avl;
      job_vtype_i = '{vill: 1'b0, vma: 1'b0, vta: 1'b0, vsew: sew, vlmul: lmul};
      job_func3_i = f3;
      job_vs1_i   = vs1;
      job_valid_i = 1'b1;
      @(posedge clk_i);
      #1 job_valid_i = 1'b0;
   endtask

   // Collects handshaken words until done/err; checks that stalled words hold still.
   task automatic run_job(input bit rand_ready, input int budget);
      bit stalled = 1'b0;
      logic [31:0] held_w = '0;
      logic [31:0] held_v = '0;
      nwords = 0; got_done = 0; got_err = 0; hs_cycle = -1; end_cycle = -1;
      for (int c = 0; c < budget; c++) begin
         @(negedge clk_i);
         instr_ready_i = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
         if (done_o || err_o) begin
            got_done  = done_o;
            got_err   = err_o;
            end_cycle = c;
            break;
         end
         if (instr_valid_o) begin
            if (stalled) begin
               check("stall_word", instr_o, held_w);
               check("stall_vl", vl_o, held_v);
            end
            if (instr_ready_i) begin
               if (nwords < 8) begin
                  words[nwords] = instr_o;
                  vls[nwords]   = vl_o;
               end
               nwords++;
               hs_cycle = c;
               stalled  = 1'b0;
            end else begin
               stalled = 1'b1;
               held_w  = instr_o;
               held_v  = vl_o;
            end
         end
      end
      if (!got_done && !got_err) check("job_timeout", 32'd0, 32'd1);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] exp_w [6];
      logic [31:0] exp_v [6];
      rst_i = 1'b1; job_valid_i = 1'b0; instr_ready_i = 1'b0; job_avl_i = '0;
      job_vtype_i = '0; job_func6_i = 6'd0; job_func3_i = OPIVV; job_vm_i = 1'b1;
      job_vd_i = 5'd1; job_vs2_i = 5'd2; job_vs1_i = 5'd3; job_rs1_i = 5'd10; job_rd_i = 5'd5;
      repeat (3) @(posedge clk_i);
      @(negedge clk_i);
      check("rst_job_ready", 32'(job_ready_o), 32'd1);
      check("rst_valid", 32'(instr_valid_o), 32'd0);
      check("rst_instr", instr_o, 32'd0);
      check("rst_vl", vl_o, 32'd0);
      check("rst_done", 32'(done_o), 32'd0);
      check("rst_err", 32'(err_o), 32'd0);
      rst_i = 1'b0;

      // avl=300, e32/m1: VLMAX=128 -> strips 128,128,44, all via vsetvli
      exp_w = '{W_VSETVLI_E32, W_VADD_VV, W_VSETVLI_E32, W_VADD_VV, W_VSETVLI_E32, W_VADD_VV};
      exp_v = '{32'd128, 32'd128, 32'd128, 32'd128, 32'd44, 32'd44};
      submit(32'd300, EW32, LMUL_1, OPIVV, 5'd3);
      run_job(1'b0, 100);
      check("t1_nwords", 32'(nwords), 32'd6);
      for (int i = 0; i < 6; i++) begin
         check($sformatf("t1_word%0d", i), words[i], exp_w[i]);
         check($sformatf("t1_vl%0d", i), vls[i], exp_v[i]);
      end
      check("t1_done", 32'(got_done), 32'd1);
      check("t1_done_timing", 32'(end_cycle), 32'(hs_cycle + 1));
      check("t1_ready_at_done", 32'(job_ready_o), 32'd1);
      @(negedge clk_i);
      check("t1_done_one_cycle", 32'(done_o), 32'd0);

      // avl=20 fits the immediate form
      submit(32'd20, EW32, LMUL_1, OPIVV, 5'd3);
      run_job(1'b0, 50);
      check("t2_nwords", 32'(nwords), 32'd2);
      check("t2_word0", words[0], W_VSETIVLI_20);
      check("t2_vl0", vls[0], 32'd20);
      check("t2_word1", words[1], W_VADD_VV);
      check("t2_done", 32'(got_done), 32'd1);

      // illegal jobs: reserved LMUL, e64/mf8, non-OPIV func3
      submit(32'd50, EW32, LMUL_RSVD, OPIVV, 5'd3);
      run_job(1'b0, 20);
      check("t3a_err", 32'(got_err), 32'd1);
      check("t3a_nwords", 32'(nwords), 32'd0);
      check("t3a_ready", 32'(job_ready_o), 32'd1);
      submit(32'd50, EW64, LMUL_1_8, OPIVV, 5'd3);
      run_job(1'b0, 20);
      check("t3b_err", 32'(got_err), 32'd1);
      check("t3b_nwords", 32'(nwords), 32'd0);
      check("t3b_ready", 32'(job_ready_o), 32'd1);
      submit(32'd50, EW32, LMUL_1, OPMVV, 5'd3);
      run_job(1'b0, 20);
      check("t3c_err", 32'(got_err), 32'd1);
      check("t3c_nwords", 32'(nwords), 32'd0);

      // avl=0
      submit(32'd0, EW32, LMUL_1, OPIVV, 5'd3);
      run_job(1'b0, 20);
      check("t4_done", 32'(got_done), 32'd1);
      check("t4_err", 32'(got_err), 32'd0);
      check("t4_nwords", 32'(nwords), 32'd0);

      // avl=256, e8/m1 (VLMAX=512), random backpressure, OPIVI simm5=7
      submit(32'd256, EW8, LMUL_1, OPIVI, 5'd7);
      run_job(1'b1, 400);
      check("t5_nwords", 32'(nwords), 32'd2);
      check("t5_word0", words[0], W_VSETVLI_E8);
      check("t5_vl0", vls[0], 32'd256);
      check("t5_word1", words[1], W_VADD_VI7);
      check("t5_done", 32'(got_done), 32'd1);

      // reset while the arith word is stalled
      submit(32'd300, EW32, LMUL_1, OPIVV, 5'd3);
      @(negedge clk_i);
      instr_ready_i = 1'b1;
      check("t6_vset_valid", 32'(instr_valid_o), 32'd1);
      @(posedge clk_i);
      @(negedge clk_i);
      instr_ready_i = 1'b0;
      check("t6_arith_valid", 32'(instr_valid_o), 32'd1);
      check("t6_arith_word", instr_o, W_VADD_VV);
      rst_i = 1'b1;
      @(posedge clk_i);
      @(negedge clk_i);
      rst_i = 1'b0;
      check("t6_valid_after_rst", 32'(instr_valid_o), 32'd0);
      check("t6_ready_after_rst", 32'(job_ready_o), 32'd1);
      submit(32'd31, EW32, LMUL_1, OPIVV, 5'd3);
      run_job(1'b0, 50);
      check("t6_nwords", 32'(nwords), 32'd2);
      check("t6_word0", words[0], W_VSETIVLI_31);
      check("t6_vl0", vls[0], 32'd31);
      check("t6_done", 32'(got_done), 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/rvv_strip_encoder.md
Name: rvv_strip_encoder

Overview:
Instruction-stream generator that produces, rather than consumes, RVV encodings for a strip-mined vector operation.
- Accepts one job: AVL, vtype, one OPIVV/OPIVX/OPIVI arithmetic op.
- Emits legal 32-bit instruction words as a sequence: per strip, one vsetvli or vsetivli followed by the arithmetic instruction, until AVL is exhausted.
- Sits in front of Ara's dispatcher port; used in standalone Ara benches and as an accelerator front-end.

Parameters:
VLEN, 4096, vector register length in bits (power of two, 128..RISCV_MAX_VLEN)
ELEN, 64, maximum supported element width in bits
AvlWidth, 32, width of the AVL and remaining-count datapath

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous reset, active-high
job_valid_i  in  1  job request valid
job_ready_o  out  1  block idle, able to accept a job
job_avl_i  in  AvlWidth  application vector length
job_vtype_i  in  vtype_t  requested vtype (vill ignored)
job_func6_i  in  6  arithmetic func6
job_func3_i  in  opcodev_func3_e  OPIVV, OPIVX or OPIVI only
job_vm_i  in  1  mask bit
job_vd_i, job_vs2_i, job_vs1_i  in  5 each  vd; vs2; vs1/rs1/simm5 field
job_rs1_i, job_rd_i  in  5 each  scalar regs for vsetvli rs1 (AVL) and rd (vl)
instr_valid_o  out  1  instruction word valid
instr_ready_i  in  1  downstream accepts the word
instr_o  out  32  encoded instruction
vl_o  out  AvlWidth  vl of the strip currently being emitted
done_o  out  1  one-cycle pulse: job finished
err_o  out  1  one-cycle pulse: job rejected

Behaviour:
- Reset values: job_ready_o=1, instr_valid_o=0, instr_o=0, vl_o=0, done_o=0, err_o=0. Reset mid-job abandons the job; no partial word is held.
- States: IDLE, VSET, ARITH.
- IDLE:
  - job_ready_o=1.
  - On a job handshake, latch all fields; remaining <= job_avl_i.
  - Reject with err_o pulse the next cycle (stay IDLE, no instructions) if any of:
    - vlmul==LMUL_RSVD;
    - SEW > ELEN;
    - fractional LMUL with SEW > ELEN*LMUL;
    - func3 not in {OPIVV, OPIVX, OPIVI}.
  - If avl==0, pulse done_o the next cycle, stay IDLE, emit nothing.
  - Otherwise go to VSET.
- VLMAX = (VLEN/8 >> vsew), then << vlmul for LMUL_1..8, or >> (8 - vlmul) for the fractional codes. Computed combinationally from the latched vtype.
- VSET: vl = min(remaining, VLMAX); vl_o is registered on entry.
  - If remaining <= 31, emit vsetivli: func2=2'b11, zimm10={2'b0,vma,vta,vsew,vlmul}, uimm5=remaining, func3=OPCFG, rd=job_rd, opcode 7'b1010111.
  - Else emit vsetvli: func1=0, zimm11={3'b0,vma,vta,vsew,vlmul}, rs1=job_rs1, func3=OPCFG, rd, same opcode.
  - On handshake go to ARITH.
- ARITH:
  - Emit {func6, vm, vs2, vs1, func3, vd, 7'b1010111}.
  - On handshake, remaining <= remaining - vl.
  - If the new remaining==0, pulse done_o and go to IDLE; else go to VSET.
- Handshake rules:
  - instr_valid_o is registered.
  - instr_o and vl_o stay stable while valid && !ready.
  - Valid never drops without a handshake, except on reset.
  - Back-to-back words are allowed: a handshake in cycle N may present the next word in cycle N+1, with zero bubble sustained.
- A job is never accepted outside IDLE. done_o/err_o coincide with job_ready_o returning high.
- Width: remaining never underflows, since vl <= remaining. VLMAX >= 1 for every legal config and VLEN >= 128.

Decomposition:
- In rvv_pkg:
  - OpcodeVec (7'b1010111);
  - a function vlmax(vew_e, vlmul_e, VLEN);
  - a function vtype_legal(vtype_t, ELEN);
  - encoder functions enc_vsetvli, enc_vsetivli and enc_varith, returning the existing instruction unions.
- Sub-module rvv_strip_fsm is optional. The natural split is the pure encoders in the package; the module holds the FSM and output register only.

Test Plan:
1. VLEN=4096, vtype e32/m1, avl=300, OPIVV func6=0 (vadd), ready always 1:
   - Six words: vsetvli, arith (vl_o=128), vsetvli, arith (128), vsetvli, arith (44).
   - done_o pulses after the 6th handshake.
2. avl=20, e32/m1, rd=5:
   - First word = 0xC10A72D7 (vsetivli uimm5=20), vl_o=20.
   - Second word is the arith word.
3. vlmul=LMUL_RSVD, then separately e64/mf8:
   - err_o pulse, zero instructions, job_ready_o back high the next cycle.
4. avl=0: done_o pulse, instr_valid_o stays 0.
5. avl=256, e8/m1 (VLMAX=512), instr_ready_i toggling randomly:
   - Each word is stable under stall, no word lost or duplicated.
   - Exactly 2 words; vl_o=256 uses vsetvli.
6. Assert rst_i while in ARITH with valid high and ready low:
   - Next cycle: instr_valid_o=0, job_ready_o=1.
   - A new job (avl=31) then emits a vsetivli with uimm5=31.
